// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle datapath controller.
package ctrl_pkg;

    // Controller states; one instruction walks FETCH -> DECODE -> ... -> FETCH.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BEQ     = 4'd9,
        JAL     = 4'd10,
        ILLEGAL = 4'd11
    } state_t;

    // Supported major opcodes (instruction[6:0]).
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALUop handed to the ALU-control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand A select.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select.
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    // Map an opcode to the state that follows DECODE.
    function automatic state_t decode_next(input logic [6:0] op);
        state_t nxt;
        case (op)
            OP_LOAD, OP_STORE: nxt = MEMADR;
            OP_RTYPE:          nxt = EXECR;
            OP_ITYPE:          nxt = EXECI;
            OP_BEQ:            nxt = BEQ;
            OP_JAL:            nxt = JAL;
            default:           nxt = ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle RISC-V datapath.
// Outputs depend on the current state plus the zero and mem_ready inputs;
// every output is forced low while rst is high, without waiting for a clock.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] ALUop,
    output logic       trap
);

    state_t state_q;
    state_t state_d;

    logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c;
    logic       pc_write_c, reg_write_c, trap_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c, alu_op_c;

    // State register; reset returns to FETCH and abandons any instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic; mem_ready only matters in the states that request memory.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE:  state_d = decode_next(opcode);
            MEMADR:  state_d = (opcode == OP_STORE) ? MEMWR : MEMRD;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (mem_ready) state_d = FETCH;
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BEQ:     state_d = FETCH;
            JAL:     state_d = FETCH;
            ILLEGAL: state_d = ILLEGAL;
            default: state_d = FETCH;
        endcase
    end

    // Per-state control decode; anything not named for a state stays 0.
    always_comb begin
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        trap_c       = 1'b0;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        result_src_c = RES_ALUOUT;
        alu_op_c     = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_a_c  = SRCA_PC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURES;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
            end
            DECODE: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
            end
            MEMADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
            end
            MEMRD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
            end
            MEMWB: begin
                result_src_c = RES_MEMDATA;
                reg_write_c  = 1'b1;
            end
            MEMWR: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
            end
            EXECR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                alu_op_c    = ALUOP_FUNCT;
            end
            EXECI: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_FUNCT;
            end
            ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
            end
            BEQ: begin
                alu_src_a_c  = SRCA_RS1;
                alu_src_b_c  = SRCB_RS2;
                alu_op_c     = ALUOP_SUB;
                result_src_c = RES_ALUOUT;
                pc_write_c   = zero;
            end
            JAL: begin
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                alu_op_c     = ALUOP_ADD;
                result_src_c = RES_ALUOUT;
                pc_write_c   = 1'b1;
                reg_write_c  = 1'b1;
            end
            ILLEGAL: trap_c = 1'b1;
            default: ;
        endcase
    end

    // Reset gating keeps every output low for as long as rst is held.
    assign mem_req    = mem_req_c   & ~rst;
    assign mem_write  = mem_write_c & ~rst;
    assign adr_src    = adr_src_c   & ~rst;
    assign ir_write   = ir_write_c  & ~rst;
    assign pc_write   = pc_write_c  & ~rst;
    assign reg_write  = reg_write_c & ~rst;
    assign trap       = trap_c      & ~rst;
    assign alu_src_a  = alu_src_a_c  & {2{~rst}};
    assign alu_src_b  = alu_src_b_c  & {2{~rst}};
    assign result_src = result_src_c & {2{~rst}};
    assign ALUop      = alu_op_c     & {2{~rst}};

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class one
// cycle at a time and checks state and the full output vector each cycle.
module tb_multicycle_control;
    import ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap;
    logic [1:0] alu_src_a, alu_src_b, result_src, ALUop;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .ALUop(ALUop), .trap(trap)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of all outputs:
    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a[1:0], b[1:0], rs[1:0], op[1:0], trap}
    function automatic logic [14:0] ov(input logic mr, input logic mw, input logic ad,
                                       input logic ir, input logic pc, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [1:0] op,
                                       input logic tr);
        return {mr, mw, ad, ir, pc, rw, a, b, rs, op, tr};
    endfunction

    function automatic logic [14:0] outs();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, ALUop, trap};
    endfunction

    // Hand-derived per-state expectations.
    localparam logic [14:0] E_ZERO    = 15'b0;
    localparam logic [14:0] E_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b10,2'b00,1'b0};
    localparam logic [14:0] E_FETCH_W = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,2'b00,1'b0};
    localparam logic [14:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_MEMRD   = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b01,2'b00,1'b0};
    localparam logic [14:0] E_MEMWR   = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_EXECR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b10,1'b0};
    localparam logic [14:0] E_EXECI   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b10,1'b0};
    localparam logic [14:0] E_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_BEQ_T   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b00,2'b01,1'b0};
    localparam logic [14:0] E_BEQ_N   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b01,1'b0};
    localparam logic [14:0] E_JAL     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b01,2'b10,2'b00,2'b00,1'b0};
    localparam logic [14:0] E_ILLEGAL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1};

    // Compare state and outputs now (called mid-cycle, after inputs settle).
    task automatic check(input string tag, input state_t s_exp, input logic [14:0] o_exp);
        n_cmp++;
        assert (dut.state_q === s_exp) else begin
            n_bad++;
            $error("FAIL %s state: got %0d want %0d", tag, dut.state_q, s_exp);
        end
        n_cmp++;
        assert (outs() === o_exp) else begin
            n_bad++;
            $error("FAIL %s outputs: got %b want %b", tag, outs(), o_exp);
        end
    endtask

    // Apply inputs at the falling edge, check, then advance one full cycle.
    task automatic step(input string tag, input logic [6:0] op, input logic rdy,
                        input logic z, input state_t s_exp, input logic [14:0] o_exp);
        opcode    = op;
        mem_ready = rdy;
        zero      = z;
        #1;
        check(tag, s_exp, o_exp);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; opcode = 7'b0; zero = 1'b0; mem_ready = 1'b1;
        #2;
        check("reset_hold", FETCH, E_ZERO);
        @(negedge clk);
        check("reset_hold_clk", FETCH, E_ZERO);
        rst = 1'b0;

        // add with a one-cycle fetch stall first, then 4 cycles.
        step("add_fetch_stall", OP_RTYPE, 1'b0, 1'b0, FETCH,  E_FETCH_W);
        step("add_fetch",       OP_RTYPE, 1'b1, 1'b0, FETCH,  E_FETCH_R);
        step("add_decode",      OP_RTYPE, 1'b0, 1'b0, DECODE, E_DECODE);
        step("add_execr",       OP_RTYPE, 1'b0, 1'b0, EXECR,  E_EXECR);
        step("add_aluwb",       OP_RTYPE, 1'b0, 1'b0, ALUWB,  E_ALUWB);

        // addi: 4 cycles through EXECI.
        step("addi_fetch",  OP_ITYPE, 1'b1, 1'b0, FETCH,  E_FETCH_R);
        step("addi_decode", OP_ITYPE, 1'b1, 1'b0, DECODE, E_DECODE);
        step("addi_execi",  OP_ITYPE, 1'b1, 1'b0, EXECI,  E_EXECI);
        step("addi_aluwb",  OP_ITYPE, 1'b1, 1'b0, ALUWB,  E_ALUWB);

        // lw with two wait cycles in MEMRD: 7 cycles.
        step("lw_fetch",   OP_LOAD, 1'b1, 1'b0, FETCH,  E_FETCH_R);
        step("lw_decode",  OP_LOAD, 1'b0, 1'b0, DECODE, E_DECODE);
        step("lw_memadr",  OP_LOAD, 1'b1, 1'b0, MEMADR, E_MEMADR);
        step("lw_memrd_w1", OP_LOAD, 1'b0, 1'b0, MEMRD, E_MEMRD);
        step("lw_memrd_w2", OP_LOAD, 1'b0, 1'b0, MEMRD, E_MEMRD);
        step("lw_memrd",   OP_LOAD, 1'b1, 1'b0, MEMRD,  E_MEMRD);
        step("lw_memwb",   OP_LOAD, 1'b0, 1'b0, MEMWB,  E_MEMWB);

        // beq taken.
        step("beqt_fetch",  OP_BEQ, 1'b1, 1'b0, FETCH,  E_FETCH_R);
        step("beqt_decode", OP_BEQ, 1'b1, 1'b0, DECODE, E_DECODE);
        step("beqt_beq",    OP_BEQ, 1'b1, 1'b1, BEQ,    E_BEQ_T);

        // beq not taken.
        step("beqn_fetch",  OP_BEQ, 1'b1, 1'b1, FETCH,  E_FETCH_R);
        step("beqn_decode", OP_BEQ, 1'b1, 1'b1, DECODE, E_DECODE);
        step("beqn_beq",    OP_BEQ, 1'b1, 1'b0, BEQ,    E_BEQ_N);

        // sw with one wait cycle in MEMWR.
        step("sw_fetch",    OP_STORE, 1'b1, 1'b0, FETCH,  E_FETCH_R);
        step("sw_decode",   OP_STORE, 1'b1, 1'b0, DECODE, E_DECODE);
        step("sw_memadr",   OP_STORE, 1'b0, 1'b0, MEMADR, E_MEMADR);
        step("sw_memwr_w",  OP_STORE, 1'b0, 1'b0, MEMWR,  E_MEMWR);
        step("sw_memwr",    OP_STORE, 1'b1, 1'b0, MEMWR,  E_MEMWR);

        // jal: 3 cycles.
        step("jal_fetch",  OP_JAL, 1'b1, 1'b0, FETCH,  E_FETCH_R);
        step("jal_decode", OP_JAL, 1'b1, 1'b0, DECODE, E_DECODE);
        step("jal_jal",    OP_JAL, 1'b1, 1'b0, JAL,    E_JAL);

        // Reset mid-MEMRD, asserted between clock edges.
        step("rstmid_fetch",  OP_LOAD, 1'b1, 1'b0, FETCH,  E_FETCH_R);
        step("rstmid_decode", OP_LOAD, 1'b1, 1'b0, DECODE, E_DECODE);
        step("rstmid_memadr", OP_LOAD, 1'b1, 1'b0, MEMADR, E_MEMADR);
        mem_ready = 1'b0;
        #1;
        check("rstmid_memrd", MEMRD, E_MEMRD);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_async", FETCH, E_ZERO);
        @(negedge clk);
        rst = 1'b0;
        step("rstmid_after", OP_LOAD, 1'b0, 1'b0, FETCH, E_FETCH_W);

        // Illegal opcode: trap sticky for 20 cycles, then async clear.
        step("ill_fetch",  7'b1111111, 1'b1, 1'b0, FETCH,  E_FETCH_R);
        step("ill_decode", 7'b1111111, 1'b1, 1'b0, DECODE, E_DECODE);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("ill_hold%0d", i), OP_RTYPE, i[0], i[1], ILLEGAL, E_ILLEGAL);
        end
        #2;
        rst = 1'b1;
        #1;
        check("ill_async_clear", FETCH, E_ZERO);
        @(negedge clk);
        rst = 1'b0;
        step("ill_after", OP_RTYPE, 1'b1, 1'b0, FETCH, E_FETCH_R);
        step("ill_after_decode", OP_RTYPE, 1'b1, 1'b0, DECODE, E_DECODE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  async active-high reset.
- opcode  in  7  instruction[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  request is a store.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and OldPC.
- pc_write  out  1  update PC (jump or taken beq).
- reg_write  out  1  register-file write.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result.
- ALUop  out  2  to the downstream ALU-control decoder: 00 add, 01 sub, 10 funct-decoded.
- trap  out  1  illegal opcode seen; sticky.

Function
REQ-003 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL; outputs are a function of state plus zero and mem_ready only.
REQ-004 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ALUop=00, result_src=10.
- When mem_ready=1: ir_write=1 and pc_write=1 in that cycle, then go to DECODE.
- Otherwise stay in FETCH with ir_write=0 and pc_write=0.
REQ-005 DECODE: alu_src_a=01, alu_src_b=01, ALUop=00 (branch target precompute); next state by opcode:
- 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other -> ILLEGAL.
REQ-006 MEMADR: alu_src_a=10, alu_src_b=01, ALUop=00; -> MEMRD for load, MEMWR for store.
REQ-007 MEMRD: mem_req=1, adr_src=1; hold until mem_ready=1, then -> MEMWB.
REQ-008 MEMWB: result_src=01, reg_write=1; -> FETCH.
REQ-009 MEMWR: mem_req=1, mem_write=1, adr_src=1; hold until mem_ready=1, then -> FETCH.
REQ-010 EXECR: alu_src_a=10, alu_src_b=00, ALUop=10; -> ALUWB.
REQ-011 EXECI: alu_src_a=10, alu_src_b=01, ALUop=10; -> ALUWB.
REQ-012 ALUWB: result_src=00, reg_write=1; -> FETCH.
REQ-013 BEQ: alu_src_a=10, alu_src_b=00, ALUop=01, result_src=00, pc_write=zero; -> FETCH.
REQ-014 JAL: alu_src_a=01, alu_src_b=10, ALUop=00, result_src=00, pc_write=1, reg_write=1; -> FETCH.
REQ-015 ILLEGAL: all strobes 0, trap=1; remains in ILLEGAL until reset.
REQ-016 Outputs not listed for a state SHALL be 0.
REQ-017 Strobes (mem_req, mem_write, ir_write, pc_write, reg_write) SHALL never assert together with trap.
REQ-018 Cycle counts with mem_ready=1 at every request:
- R/I-type and sw: 4 cycles.
- lw: 5 cycles.
- beq and jal: 3 cycles.
- Each additional cycle of mem_ready=0 extends the count by one.
REQ-019 mem_ready SHALL be ignored in states that do not assert mem_req.

Reset
REQ-020 While rst=1 the state SHALL be FETCH and every output SHALL be 0, independent of clk.
REQ-021 After rst deasserts, the first rising edge SHALL evaluate FETCH normally; a rst assertion mid-instruction SHALL abandon it with no further strobes.

Structure
REQ-022 Package ctrl_pkg SHALL hold:
- the state enum;
- opcode constants;
- ALUop, alu_src_a, alu_src_b and result_src encodings.
REQ-023 The block SHALL be a single flat module (state register plus next-state/output logic) with no sub-modules.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- add (0110011), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; ALUop=10 in EXECR; reg_write=1 in cycle 4 only.
- lw (0000011), mem_ready low for 2 cycles in MEMRD -> 7 cycles total; reg_write with result_src=01 in the last cycle.
- beq with zero=1 -> pc_write=1 in BEQ, ALUop=01; repeat with zero=0 -> pc_write=0 in BEQ.
- sw (0100011) -> mem_write=1 and adr_src=1 only in MEMWR; reg_write never asserts.
- opcode 1111111 -> ILLEGAL after DECODE; trap=1 held for 20 cycles; rst clears trap to 0 asynchronously.
- rst asserted mid-MEMRD (between edges) -> all outputs 0 immediately; state FETCH after release.
